video_clk_gen: RTL and testbench

Parametrised multi-channel clock-enable generator for the video subsystem, clocked from the 50 MHz board reference. Each channel has a phase accumulator (fractional-N) that produces a one-cycle clk_en strobe and a square-wave outclk at f_ref*step/2^ACC_W. Step values can be reprogrammed at run time. A settle sequencer drives a locked output, so downstream video timing logic sees the same readiness contract it gets from a PLL.

---
 rtl/video_clk_gen_if.sv | 22 ++
 rtl/video_clk_gen.sv | 138 +++++++++++++
 tb/tb_video_clk_gen.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/video_clk_gen_if.sv
// Configuration channel of video_clk_gen: valid/ready transfer of a step
// (and, with VIDEO_CLK_GEN_PHASE_EN, a start phase) to one target channel.
interface video_clk_gen_if #(
    parameter int CHAN_W = 1,
    parameter int ACC_W  = 16
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CHAN_W-1:0] cfg_chan;
    logic [ACC_W-1:0]  cfg_step;
    logic [ACC_W-1:0]  cfg_phase;

    modport master (
        output cfg_valid, cfg_chan, cfg_step, cfg_phase,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_chan, cfg_step, cfg_phase,
        output cfg_ready
    );
endinterface

// File: rtl/video_clk_gen.sv
// Multi-channel fractional-N clock-enable generator with PLL-style locked output.
// Optional macro VIDEO_CLK_GEN_PHASE_EN adds a programmable start phase per channel.
module video_clk_gen #(
    parameter int               NUM_CLKS      = 2,
    parameter int               ACC_W         = 16,
    parameter int               SETTLE_CYCLES = 64,
    parameter logic [ACC_W-1:0] DEFAULT_STEP  = 16'h8000,
    parameter int               CHAN_W        = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1
) (
    input  logic                refclk,
    input  logic                rst_n,
    input  logic                enable,
    video_clk_gen_if.slave      cfg,
    output logic [NUM_CLKS-1:0] clk_en,
    output logic [NUM_CLKS-1:0] outclk,
    output logic                locked
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_SETTLE,
        ST_LOCKED
    } state_t;

    state_t                            r_state;
    state_t                            w_state_nxt;
    logic [CNT_W-1:0]                  r_cnt;
    logic [NUM_CLKS-1:0][ACC_W-1:0]    r_acc;
    logic [NUM_CLKS-1:0][ACC_W-1:0]    r_step;
    logic [NUM_CLKS-1:0][ACC_W-1:0]    w_step_nxt;
    logic [NUM_CLKS-1:0][ACC_W-1:0]    w_start;
    logic [NUM_CLKS-1:0][ACC_W:0]      w_sum;
    logic [NUM_CLKS-1:0]               r_clk_en;
    logic [NUM_CLKS-1:0]               r_outclk;
    logic                              r_locked;
    logic                              r_cfg_ready;
    logic [CHAN_W-1:0]                 w_chan;
    logic                              w_xfer;
    logic                              w_hit;
    logic                              w_restart;
    logic                              w_run_out;

    assign w_chan = cfg.cfg_chan;
    assign w_xfer = cfg.cfg_valid & r_cfg_ready;
    // Out-of-range channels complete the handshake but touch nothing.
    assign w_hit  = w_xfer && (int'(w_chan) < NUM_CLKS);

    always_comb begin
        w_step_nxt = r_step;
        for (int i = 0; i < NUM_CLKS; i++) begin
            if (w_hit && int'(w_chan) == i)
                w_step_nxt[i] = cfg.cfg_step;
        end
    end

`ifdef VIDEO_CLK_GEN_PHASE_EN
    logic [NUM_CLKS-1:0][ACC_W-1:0] r_phase;
    logic [NUM_CLKS-1:0][ACC_W-1:0] w_phase_nxt;

    always_comb begin
        w_phase_nxt = r_phase;
        for (int i = 0; i < NUM_CLKS; i++) begin
            if (w_hit && int'(w_chan) == i)
                w_phase_nxt[i] = cfg.cfg_phase;
        end
    end

    // A phase written on the restarting edge is already the one loaded.
    assign w_start = w_phase_nxt;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n)
            r_phase <= '0;
        else
            r_phase <= w_phase_nxt;
    end
`else
    assign w_start = '0;
`endif

    genvar g;
    generate
        for (g = 0; g < NUM_CLKS; g++) begin : g_sum
            assign w_sum[g] = {1'b0, r_acc[g]} + {1'b0, r_step[g]};
        end
    endgenerate

    // Enable low wins the state decision; a write in HOLD holds one more cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = ST_HOLD;
        end else begin
            case (r_state)
                ST_HOLD:   w_state_nxt = w_hit ? ST_HOLD : ST_SETTLE;
                ST_SETTLE: w_state_nxt = (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) ? ST_LOCKED : ST_SETTLE;
                ST_LOCKED: w_state_nxt = w_hit ? ST_SETTLE : ST_LOCKED;
                default:   w_state_nxt = ST_HOLD;
            endcase
        end
    end

    assign w_restart = (r_state == ST_HOLD) || (w_state_nxt == ST_HOLD) ||
                       (r_state == ST_LOCKED && w_state_nxt == ST_SETTLE);
    assign w_run_out = (r_state == ST_LOCKED) && (w_state_nxt == ST_LOCKED);

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_HOLD;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_step      <= {NUM_CLKS{DEFAULT_STEP}};
            r_clk_en    <= '0;
            r_outclk    <= '0;
            r_locked    <= 1'b0;
            r_cfg_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_locked    <= (w_state_nxt == ST_LOCKED);
            r_cfg_ready <= (w_state_nxt != ST_SETTLE);
            r_cnt       <= (r_state == ST_SETTLE) ? r_cnt + 1'b1 : '0;
            r_step      <= w_step_nxt;
            for (int i = 0; i < NUM_CLKS; i++) begin
                r_acc[i]    <= w_restart ? w_start[i] : w_sum[i][ACC_W-1:0];
                r_clk_en[i] <= w_run_out & w_sum[i][ACC_W];
                r_outclk[i] <= w_run_out & w_sum[i][ACC_W-1];
            end
        end
    end

    assign clk_en        = r_clk_en;
    assign outclk        = r_outclk;
    assign locked        = r_locked;
    assign cfg.cfg_ready = r_cfg_ready;

endmodule

// File: tb/tb_video_clk_gen.sv
// Bench for video_clk_gen: directed scenarios plus random traffic, all checked
// every cycle against a closed-form model (acc = start + k*step since restart).
module tb_video_clk_gen;
    localparam int NUM = 3;
    localparam int ACC = 16;
    localparam int SC  = 64;
    localparam int CW  = 2;
    localparam int MH  = 0;
    localparam int MS  = 1;
    localparam int ML  = 2;

    logic           refclk;
    logic           rst_n;
    logic           enable;
    logic [NUM-1:0] clk_en;
    logic [NUM-1:0] outclk;
    logic           locked;

    video_clk_gen_if #(.CHAN_W(CW), .ACC_W(ACC)) cfg_if ();

    video_clk_gen #(
        .NUM_CLKS(NUM), .ACC_W(ACC), .SETTLE_CYCLES(SC), .DEFAULT_STEP(16'h8000)
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .enable(enable), .cfg(cfg_if),
        .clk_en(clk_en), .outclk(outclk), .locked(locked)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    int checks;
    int errors;

    int             m_mode;
    int             m_settled;
    longint         m_k;
    logic [ACC-1:0] m_step  [NUM];
    logic [ACC-1:0] m_phase [NUM];
    logic [NUM-1:0] m_clk_en;
    logic [NUM-1:0] m_outclk;
    logic           m_ready;
    logic           m_locked;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = MH; m_settled = 0; m_k = 0;
        for (int i = 0; i < NUM; i++) begin
            m_step[i] = 16'h8000; m_phase[i] = '0;
        end
        m_clk_en = '0; m_outclk = '0; m_ready = 1'b0; m_locked = 1'b0;
    endtask

    // Closed form: after k accumulations since restart acc = start + k*step;
    // a strobe is a change in the integer part, outclk is bit ACC-1.
    task automatic model_step();
        bit     hit;
        int     nm;
        int     ch;
        longint s;
        longint p;
        longint st;
        ch  = int'(cfg_if.cfg_chan);
        hit = cfg_if.cfg_valid && m_ready && (ch < NUM);
        if (!enable)           nm = MH;
        else if (m_mode == MH) nm = hit ? MH : MS;
        else if (m_mode == MS) nm = (m_settled + 1 >= SC) ? ML : MS;
        else                   nm = hit ? MS : ML;
        if (nm != MH && (m_mode == MS || (m_mode == ML && nm == ML))) m_k = m_k + 1;
        else m_k = 0;
        m_settled = (m_mode == MS && nm == MS) ? m_settled + 1 : 0;
        if (hit) begin
            m_step[ch]  = cfg_if.cfg_step;
            m_phase[ch] = cfg_if.cfg_phase;
        end
        for (int i = 0; i < NUM; i++) begin
`ifdef VIDEO_CLK_GEN_PHASE_EN
            st = longint'(m_phase[i]);
`else
            st = 0;
`endif
            if (m_mode == ML && nm == ML) begin
                s = st + m_k * longint'(m_step[i]);
                p = s - longint'(m_step[i]);
                m_clk_en[i] = ((s >> ACC) != (p >> ACC));
                m_outclk[i] = ((s >> (ACC - 1)) & 1) != 0;
            end else begin
                m_clk_en[i] = 1'b0;
                m_outclk[i] = 1'b0;
            end
        end
        m_mode   = nm;
        m_ready  = (nm != MS);
        m_locked = (nm == ML);
    endtask

    task automatic compare();
        chk("clk_en",    longint'(clk_en),           longint'(m_clk_en));
        chk("outclk",    longint'(outclk),           longint'(m_outclk));
        chk("locked",    longint'(locked),           longint'(m_locked));
        chk("cfg_ready", longint'(cfg_if.cfg_ready), longint'(m_ready));
    endtask

    // One clock: model follows the edge, outputs checked 1 time unit later,
    // returns on the following falling edge where stimulus is applied.
    task automatic tick();
        @(posedge refclk);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        compare();
        @(negedge refclk);
    endtask

    task automatic wait_lock(input string nm, input int exp);
        int n;
        n = 0;
        while (!locked && n < 300) begin
            tick();
            n++;
        end
        chk(nm, n, exp);
    endtask

    task automatic count16(input int ch, output int pulses, output int highs);
        pulses = 0; highs = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            pulses += int'(clk_en[ch]);
            highs  += int'(outclk[ch]);
        end
    endtask

    task automatic write(input int ch, input logic [ACC-1:0] step, input logic [ACC-1:0] ph);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_chan  = CW'(ch);
        cfg_if.cfg_step  = step;
        cfg_if.cfg_phase = ph;
        tick();
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        int pu;
        int hi;
        int r;
        checks = 0; errors = 0;
        rst_n = 1'b0; enable = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_chan = '0;
        cfg_if.cfg_step = '0; cfg_if.cfg_phase = '0;
        model_reset();
        repeat (3) tick();
        chk("rst_locked", locked, 0);
        chk("rst_ready",  cfg_if.cfg_ready, 0);
        chk("rst_outs",   longint'({clk_en, outclk}), 0);

        // Release with enable high: lock on edge 65, then 0x8000 toggles each cycle.
        rst_n = 1'b1; enable = 1'b1;
        wait_lock("t1_lock_edge", 65);
        tick();
        chk("t1_outclk_a", outclk[0], 1);
        chk("t1_clken_a",  clk_en[0], 0);
        tick();
        chk("t1_outclk_b", outclk[0], 0);
        chk("t1_clken_b",  clk_en[0], 1);

        // Retune channel 1 while locked.
        write(1, 16'h2000, 16'h0);
        chk("t2_ready_drop",  cfg_if.cfg_ready, 0);
        chk("t2_locked_drop", locked, 0);
        wait_lock("t2_relock", 64);
        tick();
        chk("t2_ch0_aligned", outclk[0], 1);
        chk("t2_ch1_first",   outclk[1], 0);
        count16(1, pu, hi);
        chk("t2_ch1_pulses", pu, 2);
        chk("t2_ch1_highs",  hi, 8);

        // Step 0 idles; out-of-range channel is a no-op.
        write(0, 16'h0000, 16'h0);
        wait_lock("t3_relock", 64);
        count16(0, pu, hi);
        chk("t3_idle_pulses", pu, 0);
        chk("t3_idle_highs",  hi, 0);
        write(3, 16'h1234, 16'h0);
        chk("t3_oor_locked", locked, 1);
        chk("t3_oor_ready",  cfg_if.cfg_ready, 1);
        count16(0, pu, hi);
        chk("t3_oor_pulses", pu, 0);

        // Enable drop together with a write: HOLD wins, step still lands.
        enable = 1'b0;
        write(2, 16'h4000, 16'h0);
        enable = 1'b1;
        chk("t4_locked", locked, 0);
        chk("t4_outs",   longint'({clk_en, outclk}), 0);
        chk("t4_ready",  cfg_if.cfg_ready, 1);
        wait_lock("t4_relock", 65);
        count16(2, pu, hi);
        chk("t4_ch2_pulses", pu, 4);
        chk("t4_ch2_highs",  hi, 8);

        // Async reset mid-SETTLE, then steps back to default.
        write(1, 16'h1000, 16'h0);
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_async_locked", locked, 0);
        chk("t5_async_outs",   longint'({clk_en, outclk}), 0);
        chk("t5_async_ready",  cfg_if.cfg_ready, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        wait_lock("t5_relock", 65);
        for (int c = 0; c < NUM; c++) begin
            count16(c, pu, hi);
            chk($sformatf("t5_default_ch%0d", c), pu, 8);
        end

`ifdef VIDEO_CLK_GEN_PHASE_EN
        write(1, 16'h8000, 16'h8000);
        wait_lock("t6_relock", 64);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t6_antiphase", outclk[1], ~outclk[0]);
        end
`endif

        // Random traffic against the model.
        for (int it = 0; it < 4000; it++) begin
            enable = ($urandom_range(0, 299) != 0);
            cfg_if.cfg_valid = ($urandom_range(0, 39) == 0);
            cfg_if.cfg_chan  = CW'($urandom_range(0, 3));
            r = $urandom_range(0, 3);
            cfg_if.cfg_step  = (r == 0) ? ACC'($urandom) : (r == 1) ? 16'h0000 :
                               (r == 2) ? 16'h2000 : 16'h3000;
            cfg_if.cfg_phase = ACC'($urandom);
            if ($urandom_range(0, 999) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                compare();
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
